// File: rtl/banco_reg_sb.sv
// banco_reg_sb: parametrised register bank with two combinational read ports,
// one clocked write port, optional zero register, optional write-to-read
// bypass and a per-register pending scoreboard with a live pending count.
module banco_reg_sb #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] sel,
    input  logic [WIDTH-1:0]  data,
    input  logic [ADDR_W-1:0] selA,
    input  logic [ADDR_W-1:0] selB,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    input  logic              Resv,
    input  logic [ADDR_W-1:0] ResvReg,
    input  logic              UseA,
    input  logic              UseB,
    output logic              Busy1,
    output logic              Busy2,
    output logic              Stall,
    output logic [ADDR_W:0]   PendCount
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef logic [ADDR_W:0] cnt_t;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_pend;
    cnt_t             r_count;

    logic             w_wr_ok;
    logic             w_resv_ok;
    logic             w_set;
    logic             w_clr;
    logic             w_hit_a;
    logic             w_hit_b;
    logic [DEPTH-1:0] w_pend_next;

    // Register 0 swallows writes and reservations when it is hard-wired.
    assign w_wr_ok   = RegWrite && !((ZERO_REG != 0) && (sel == '0));
    assign w_resv_ok = Resv && !((ZERO_REG != 0) && (ResvReg == '0));

    // A count change happens only on a real 0->1 or 1->0 transition; a write
    // to the register being re-reserved in the same cycle is not a clear.
    assign w_set = w_resv_ok && !r_pend[ResvReg];
    assign w_clr = w_wr_ok && r_pend[sel] && !(w_resv_ok && (ResvReg == sel));

    // Next pending vector: clear on writeback, then reservation overrides it.
    always_comb begin
        // NOTE: default assigned first so every path drives the vector and no latch is inferred.
        w_pend_next = r_pend;
        if (w_wr_ok) begin
            w_pend_next[sel] = 1'b0;
        end
        if (w_resv_ok) begin
            w_pend_next[ResvReg] = 1'b1;
        end
    end

    // Register array: clocked write port, whole array cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset on purpose -- architected state must read 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            // NOTE: non-blocking so reads in this cycle still see pre-edge contents.
            r_regs[sel] <= data;
        end
    end

    // Scoreboard: pending bits and the incrementally maintained pending count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_count <= '0;
        end else begin
            r_pend  <= w_pend_next;
            r_count <= r_count + cnt_t'(w_set) - cnt_t'(w_clr);
        end
    end

    assign w_hit_a = (BYPASS != 0) && w_wr_ok && (sel == selA);
    assign w_hit_b = (BYPASS != 0) && w_wr_ok && (sel == selB);

    // Read port 1: stored value, forced zero for register 0, bypass wins.
    always_comb begin
        ReadData1 = r_regs[selA];
        if ((ZERO_REG != 0) && (selA == '0)) begin
            ReadData1 = '0;
        end
        if (w_hit_a) begin
            ReadData1 = data;
        end
    end

    // Read port 2: same structure as port 1.
    always_comb begin
        ReadData2 = r_regs[selB];
        if ((ZERO_REG != 0) && (selB == '0)) begin
            ReadData2 = '0;
        end
        if (w_hit_b) begin
            ReadData2 = data;
        end
    end

    assign Busy1     = r_pend[selA] && !w_hit_a;
    assign Busy2     = r_pend[selB] && !w_hit_b;
    assign Stall     = (UseA && Busy1) || (UseB && Busy2);
    assign PendCount = r_count;

endmodule
